// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/pipeline_hazard_controller_saturating_counter.sv
// Up-counter that sticks at all-ones, with enable and synchronous clear.
module pipeline_hazard_controller_saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    // Count up on enable, hold at all-ones once reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
//   state    | meaning
//   RUN      | normal issue; load-use stalls and redirect flushes handled here
//   MEM_WAIT | data memory access pending, whole pipeline frozen
//   HALT     | memory timed out, core frozen until reset
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_IDEX_MemRead,
    input  logic [4:0]  i_IDEX_Rt_5,
    input  logic [4:0]  i_IFID_Rs_5,
    input  logic [4:0]  i_IFID_Rt_5,
    input  logic        i_IFID_UsesRt,
    input  logic        i_EX_Redirect,
    input  logic        i_Mem_Req,
    input  logic        i_Mem_Ready,
    output logic        o_PC_Enable,
    output logic        o_IFID_Enable,
    output logic        o_IFID_Flush,
    output logic        o_IDEX_Enable,
    output logic        o_IDEX_Bubble,
    output logic        o_EXMEM_Enable,
    output logic [1:0]  o_State_2,
    output logic        o_MemTimeout,
    output logic [31:0] o_StallCycles_32,
    output logic [15:0] o_FlushCount_16
);

    state_t     state, next_state;
    logic [7:0] wait_cnt, next_wait_cnt;
    logic [8:0] cnt_step;
    logic       load_use, mem_stall;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en;
    logic       set_timeout, flush_inc, stall_inc;

    assign load_use  = i_IDEX_MemRead && (i_IDEX_Rt_5 != 5'd0) &&
                       ((i_IDEX_Rt_5 == i_IFID_Rs_5) ||
                        (i_IFID_UsesRt && (i_IDEX_Rt_5 == i_IFID_Rt_5)));
    assign mem_stall = i_Mem_Req && !i_Mem_Ready;

    // Next-state and Mealy control decode; memory stall outranks redirect outranks load-use.
    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        cnt_step      = 9'd0;
        pc_en         = 1'b0;
        ifid_en       = 1'b0;
        ifid_flush    = 1'b0;
        idex_en       = 1'b0;
        idex_bubble   = 1'b0;
        exmem_en      = 1'b0;
        set_timeout   = 1'b0;
        flush_inc     = 1'b0;
        case (state)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    // The first frozen cycle counts as wait 1, so a timeout of 1 halts straight from RUN.
                    cnt_step = (state == ST_RUN) ? 9'd1 : ({1'b0, wait_cnt} + 9'd1);
                    if (cnt_step >= 9'(MEM_TIMEOUT)) begin
                        next_state    = ST_HALT;
                        next_wait_cnt = 8'd0;
                        set_timeout   = 1'b1;
                    end else begin
                        next_state    = ST_MEM_WAIT;
                        next_wait_cnt = cnt_step[7:0];
                    end
                end else begin
                    next_state    = ST_RUN;
                    next_wait_cnt = 8'd0;
                    if (i_EX_Redirect) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_en     = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_en    = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (load_use) begin
                        idex_en     = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_en    = 1'b1;
                    end else begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                    end
                end
            end
            default: begin
                next_state = ST_HALT;
            end
        endcase
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_RUN;
            wait_cnt     <= 8'd0;
            o_MemTimeout <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
            if (set_timeout) begin
                o_MemTimeout <= 1'b1;
            end
        end
    end

    assign stall_inc = (state != ST_HALT) && !pc_en;

    pipeline_hazard_controller_saturating_counter #(.WIDTH(32)) u_stall_count (
        .clk    (clk),
        .reset  (reset),
        .enable (stall_inc),
        .clear  (1'b0),
        .count  (o_StallCycles_32)
    );

    pipeline_hazard_controller_saturating_counter #(.WIDTH(16)) u_flush_count (
        .clk    (clk),
        .reset  (reset),
        .enable (flush_inc),
        .clear  (1'b0),
        .count  (o_FlushCount_16)
    );

    assign o_PC_Enable    = pc_en && !reset;
    assign o_IFID_Enable  = ifid_en && !reset;
    assign o_IFID_Flush   = ifid_flush && !reset;
    assign o_IDEX_Enable  = idex_en && !reset;
    assign o_IDEX_Bubble  = idex_bubble && !reset;
    assign o_EXMEM_Enable = exmem_en && !reset;
    assign o_State_2      = state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_IDEX_MemRead;
    logic [4:0]  i_IDEX_Rt_5;
    logic [4:0]  i_IFID_Rs_5;
    logic [4:0]  i_IFID_Rt_5;
    logic        i_IFID_UsesRt;
    logic        i_EX_Redirect;
    logic        i_Mem_Req;
    logic        i_Mem_Ready;
    logic        o_PC_Enable;
    logic        o_IFID_Enable;
    logic        o_IFID_Flush;
    logic        o_IDEX_Enable;
    logic        o_IDEX_Bubble;
    logic        o_EXMEM_Enable;
    logic [1:0]  o_State_2;
    logic        o_MemTimeout;
    logic [31:0] o_StallCycles_32;
    logic [15:0] o_FlushCount_16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.MEM_TIMEOUT(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_IDEX_MemRead   (i_IDEX_MemRead),
        .i_IDEX_Rt_5      (i_IDEX_Rt_5),
        .i_IFID_Rs_5      (i_IFID_Rs_5),
        .i_IFID_Rt_5      (i_IFID_Rt_5),
        .i_IFID_UsesRt    (i_IFID_UsesRt),
        .i_EX_Redirect    (i_EX_Redirect),
        .i_Mem_Req        (i_Mem_Req),
        .i_Mem_Ready      (i_Mem_Ready),
        .o_PC_Enable      (o_PC_Enable),
        .o_IFID_Enable    (o_IFID_Enable),
        .o_IFID_Flush     (o_IFID_Flush),
        .o_IDEX_Enable    (o_IDEX_Enable),
        .o_IDEX_Bubble    (o_IDEX_Bubble),
        .o_EXMEM_Enable   (o_EXMEM_Enable),
        .o_State_2        (o_State_2),
        .o_MemTimeout     (o_MemTimeout),
        .o_StallCycles_32 (o_StallCycles_32),
        .o_FlushCount_16  (o_FlushCount_16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controls packed as {pc, ifid_en, flush, idex_en, bubble, exmem}.
    function automatic logic [31:0] ctl();
        return {26'd0, o_PC_Enable, o_IFID_Enable, o_IFID_Flush,
                o_IDEX_Enable, o_IDEX_Bubble, o_EXMEM_Enable};
    endfunction

    task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic ur, input logic rd,
                         input logic rq, input logic ry);
        i_IDEX_MemRead = mr;
        i_IDEX_Rt_5    = ert;
        i_IFID_Rs_5    = rs;
        i_IFID_Rt_5    = rt;
        i_IFID_UsesRt  = ur;
        i_EX_Redirect  = rd;
        i_Mem_Req      = rq;
        i_Mem_Ready    = ry;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check("reset_ctl", ctl(), 32'h00);
        check("reset_state", 32'(o_State_2), 0);
        check("reset_timeout", 32'(o_MemTimeout), 0);
        check("reset_stall", o_StallCycles_32, 0);
        check("reset_flush", 32'(o_FlushCount_16), 0);

        @(negedge clk); reset = 1'b0; #1;
        check("idle_ctl", ctl(), 32'b110101);

        // lw $8 in EX, add rs=$8 in ID
        @(negedge clk); drive(1, 8, 8, 3, 1, 0, 0, 0); #1;
        check("lu_ctl", ctl(), 32'b000111);
        @(posedge clk); #1;
        check("lu_stall", o_StallCycles_32, 1);
        @(negedge clk); drive(0, 0, 8, 3, 1, 0, 0, 0); #1;
        check("lu_after_bubble", ctl(), 32'b110101);

        // destination $0 never hazards
        @(negedge clk); drive(1, 0, 0, 0, 1, 0, 0, 0); #1;
        check("lu_r0_ctl", ctl(), 32'b110101);
        @(posedge clk); #1;
        check("lu_r0_stall", o_StallCycles_32, 1);

        // rt match only counts when ID reads rt
        @(negedge clk); drive(1, 9, 3, 9, 0, 0, 0, 0); #1;
        check("lu_rt_unused", ctl(), 32'b110101);
        @(negedge clk); drive(1, 9, 3, 9, 1, 0, 0, 0); #1;
        check("lu_rt_used", ctl(), 32'b000111);
        @(posedge clk); #1;
        check("lu_rt_stall", o_StallCycles_32, 2);

        // redirect beats load-use
        @(negedge clk); drive(1, 8, 8, 0, 0, 1, 0, 0); #1;
        check("redir_lu_ctl", ctl(), 32'b111111);
        @(posedge clk); #1;
        check("redir_flush", 32'(o_FlushCount_16), 1);
        check("redir_stall", o_StallCycles_32, 2);

        // memory stall 3 cycles with pending redirect, ready on 4th waiting cycle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(0, 0, 0, 0, 0, 1, 1, 0); #1;
            check("ms_ctl", ctl(), 32'b000000);
            @(posedge clk); #1;
            check("ms_state", 32'(o_State_2), 1);
        end
        check("ms_stall", o_StallCycles_32, 5);
        @(negedge clk); drive(0, 0, 0, 0, 0, 1, 1, 1); #1;
        check("ms_ready_ctl", ctl(), 32'b111111);
        @(posedge clk); #1;
        check("ms_ready_state", 32'(o_State_2), 0);
        check("ms_ready_timeout", 32'(o_MemTimeout), 0);
        check("ms_ready_flush", 32'(o_FlushCount_16), 2);
        check("ms_ready_stall", o_StallCycles_32, 5);

        // timeout: never ready, HALT after 4 edges
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("to_wait_state", 32'(o_State_2), 1);
            check("to_wait_flag", 32'(o_MemTimeout), 0);
        end
        @(posedge clk); #1;
        check("to_halt_state", 32'(o_State_2), 2);
        check("to_halt_flag", 32'(o_MemTimeout), 1);
        check("to_stall", o_StallCycles_32, 9);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
        check("halt_ctl", ctl(), 32'b000000);
        @(posedge clk); @(posedge clk); #1;
        check("halt_state_hold", 32'(o_State_2), 2);
        check("halt_stall_hold", o_StallCycles_32, 9);

        // asynchronous reset mid-cycle in HALT
        #2 reset = 1'b1; #1;
        check("arst_state", 32'(o_State_2), 0);
        check("arst_timeout", 32'(o_MemTimeout), 0);
        check("arst_stall", o_StallCycles_32, 0);
        check("arst_flush", 32'(o_FlushCount_16), 0);
        check("arst_ctl", ctl(), 32'b000000);
        @(negedge clk); reset = 1'b0; #1;
        check("arst_run_ctl", ctl(), 32'b110101);

        // saturation of the stall counter
        @(negedge clk);
        force dut.u_stall_count.count = 32'hFFFF_FFFF;
        #1 release dut.u_stall_count.count;
        #1;
        check("sat_preload", o_StallCycles_32, 32'hFFFF_FFFF);
        drive(1, 8, 8, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("sat_hold", o_StallCycles_32, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage MIPS pipeline. It detects load-use hazards between ID/EX and IF/ID and flushes wrong-path instructions when a branch, jump or jr resolves in EX. It also freezes the whole pipeline while the data memory handshake is pending, and halts the core on a memory timeout. It drives the enable, flush and bubble controls of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers, and exposes status and performance counters.

## Interface
- MEM_TIMEOUT, 15: consecutive not-ready memory cycles before HALT; range 1..255.
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- i_IDEX_MemRead  in  1  instruction in EX is a load.
- i_IDEX_Rt_5  in  5  load destination register in EX.
- i_IFID_Rs_5  in  5  rs of the instruction in ID.
- i_IFID_Rt_5  in  5  rt of the instruction in ID.
- i_IFID_UsesRt  in  1  ID instruction reads rt (R-type, sw, beq/bne).
- i_EX_Redirect  in  1  taken branch, j, jal or jr resolved in EX.
- i_Mem_Req  in  1  MEM stage holds a load or store.
- i_Mem_Ready  in  1  data memory completes the access this cycle.
- o_PC_Enable  out  1  PC register load enable.
- o_IFID_Enable  out  1  IF/ID load enable.
- o_IFID_Flush  out  1  IF/ID loads zeros (nop).
- o_IDEX_Enable  out  1  ID/EX load enable.
- o_IDEX_Bubble  out  1  ID/EX loads all-zero controls.
- o_EXMEM_Enable  out  1  EX/MEM load enable.
- o_State_2  out  2  RUN=0, MEM_WAIT=1, HALT=2.
- o_MemTimeout  out  1  sticky timeout error.
- o_StallCycles_32  out  32  saturating stall-cycle counter.
- o_FlushCount_16  out  16  saturating redirect counter.

## Operation
- Load-use hazard (LU) = i_IDEX_MemRead & (i_IDEX_Rt_5 != 0) & (Rt==i_IFID_Rs_5 | (i_IFID_UsesRt & Rt==i_IFID_Rt_5)).
- MS (memory stall) = i_Mem_Req & ~i_Mem_Ready.
- The outputs are Mealy: they are combinational from the state and the inputs. Priority is MS > redirect > LU.
- RUN state:
  - MS: all four enables 0, flush and bubble 0. Next state MEM_WAIT, wait_cnt←1.
  - Else i_EX_Redirect: all enables 1, o_IFID_Flush=1, o_IDEX_Bubble=1, FlushCount+1.
  - Else LU: o_PC_Enable=0, o_IFID_Enable=0, o_IDEX_Enable=1, o_IDEX_Bubble=1, EXMEM enable 1.
  - Else: all enables 1, no flush or bubble.
- MEM_WAIT state:
  - MS: all enables 0, wait_cnt+1. When wait_cnt reaches MEM_TIMEOUT on this cycle, next state HALT and o_MemTimeout←1.
  - ~MS: evaluate exactly as RUN with MS false, next state RUN, wait_cnt←0.
- HALT state: all enables 0 and flush/bubble 0. Only reset exits HALT.
- The redirect and LU conditions are not latched. A frozen ID/EX re-presents them after the memory stall ends.
- StallCycles increments on every cycle with o_PC_Enable=0 in RUN or MEM_WAIT. It does not count in HALT.
- Both counters saturate at all-ones.

## Timing
- Reset (asynchronous, immediate): state RUN, wait_cnt 0, o_MemTimeout 0, counters 0.
- While reset is high, all enables, flush and bubble are forced to 0.
- Redirect: same cycle. The two wrong-path instructions (in IF/ID and IF) are squashed at the next edge, and the PC loads the target.
- LU costs exactly 1 stall cycle. The inserted bubble clears i_IDEX_MemRead on the next cycle.
- First MS at cycle t with Ready never asserted: HALT at t+MEM_TIMEOUT.
- Ready on the MEM_TIMEOUT-th waiting cycle: the pipeline proceeds and no timeout is raised.
- MS plus redirect in the same cycle: freeze. The redirect takes effect on the first ~MS cycle.
- Reset during MEM_WAIT or HALT returns to RUN and clears all state.

## Structure
- The shared package holds the state encoding constants (RUN/MEM_WAIT/HALT) and the MEM_TIMEOUT default.
- One sub-module, SaturatingCounter, parameterized by width, with enable and synchronous clear. It is instantiated for both performance counters.
- Hazard compare and next-state logic are written inline.

## Test plan
- Load-use: lw $8 in EX, add with rs=$8 in ID → 1 cycle with PC/IFID enable 0 and IDEX bubble 1, StallCycles=1. The same case with Rt=$0 → no stall.
- Redirect and LU in the same cycle → IFID flush=1, IDEX bubble=1, PC enable=1, FlushCount=1, StallCycles unchanged.
- Req with Ready low for 3 cycles, then high → enables 0 for 3 cycles, state MEM_WAIT, back to RUN on the Ready cycle, StallCycles=3.
- MEM_TIMEOUT=4, Ready never asserted → o_State_2=2 and o_MemTimeout=1 at t+4; all enables stay 0 afterwards.
- Reset asserted in HALT, mid-cycle → asynchronous return to RUN, o_MemTimeout 0, counters 0.
- Force StallCycles to 0xFFFFFFFF and stall once more → the value stays at 0xFFFFFFFF.
